// File: rtl/ic7402_quad_nor_if.sv
// ---------------------------------------------------------------------------
// ic7402_quad_nor_if
//   Signal bundle for the 7402 quad 2-input NOR model.
//
//   Signals (all GATES bits wide, bit i belongs to gate i):
//     a, b   : gate inputs, driven by the master (stimulus / surrounding logic)
//     y      : combinational NOR outputs, driven by the slave (the gate model)
//     y_q    : y delayed by the model's pipeline depth
//     y_chg  : one-cycle strobe, bit i high when y_q[i] changed on last edge
//
//   Modports:
//     master : drives a/b, observes y/y_q/y_chg
//     slave  : observes a/b, drives y/y_q/y_chg
// ---------------------------------------------------------------------------
interface ic7402_quad_nor_if #(
  parameter int GATES = 4
) ();

  logic [GATES-1:0] a;
  logic [GATES-1:0] b;
  logic [GATES-1:0] y;
  logic [GATES-1:0] y_q;
  logic [GATES-1:0] y_chg;

  modport master (
    output a,
    output b,
    input  y,
    input  y_q,
    input  y_chg
  );

  modport slave (
    input  a,
    input  b,
    output y,
    output y_q,
    output y_chg
  );

endinterface : ic7402_quad_nor_if

// File: rtl/ic7402_quad_nor.sv
// ---------------------------------------------------------------------------
// ic7402_quad_nor
//   Synthesizable model of the 7402 quad 2-input NOR package.
//
//   Every lane i provides:
//     y[i]     = ~(a[i] | b[i])             combinational, independent of clk
//     y_q[i]   = y[i] delayed by PIPE_STAGES rising edges of clk
//     y_chg[i] = registered strobe, high for the one cycle in which y_q[i]
//                shows a new value
//
//   Ports:
//     clk    : system clock, all registers update on the rising edge
//     rst_n  : synchronous active-low reset; loads every pipeline stage with
//              all-ones (the NOR of all-zero inputs) and clears y_chg
//     bus    : ic7402_quad_nor_if slave modport carrying a, b, y, y_q, y_chg
//
//   Parameters:
//     GATES        : number of independent NOR lanes (4 for a 7402); must
//                    match the GATES parameter of the connected interface
//     PIPE_STAGES  : register stages between y and y_q, legal range 1..4
// ---------------------------------------------------------------------------
module ic7402_quad_nor #(
  parameter int GATES       = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ic7402_quad_nor_if.slave       bus
);

  // Reject unsupported pipeline depths at elaboration time.
  generate
    if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : g_bad_pipe
      $error("ic7402_quad_nor: PIPE_STAGES must be in the range 1..4");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Combinational NOR lanes. Kept free of clk/rst_n so y is valid in reset.
  // -------------------------------------------------------------------------
  logic [GATES-1:0] y_comb;

  generate
    for (genvar gi = 0; gi < GATES; gi++) begin : g_lane
      assign y_comb[gi] = ~(bus.a[gi] | bus.b[gi]);
    end
  endgenerate

  assign bus.y = y_comb;

  // -------------------------------------------------------------------------
  // Output pipeline. Stage 0 samples y, stage k samples stage k-1, the last
  // stage is y_q.
  // -------------------------------------------------------------------------
  localparam int LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0][GATES-1:0] stage_q;
  logic [PIPE_STAGES-1:0][GATES-1:0] stage_d;
  logic [GATES-1:0]                  y_chg_q;
  logic [GATES-1:0]                  y_chg_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = y_comb;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    // The strobe compares what y_q is about to become with what it is now,
    // so it rises in the same cycle y_q shows the new value.
    y_chg_d = stage_d[LAST] ^ stage_q[LAST];
  end

  // Reset wins over capture: in-flight data is discarded and the strobe is
  // forced low even when y_q was not already all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= {PIPE_STAGES{{GATES{1'b1}}}};
      y_chg_q <= '0;
    end else begin
      stage_q <= stage_d;
      y_chg_q <= y_chg_d;
    end
  end

  assign bus.y_q   = stage_q[LAST];
  assign bus.y_chg = y_chg_q;

endmodule : ic7402_quad_nor

// File: tb/tb_ic7402_quad_nor.sv
// ---------------------------------------------------------------------------
// tb_ic7402_quad_nor
//   Two instances share clock, reset and inputs: u1 with PIPE_STAGES=1 and
//   u2 with PIPE_STAGES=2. A history of sampled inputs/reset per edge feeds
//   a reference model; a negedge process compares every output of both
//   instances each cycle. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_ic7402_quad_nor;

  localparam int G = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [G-1:0] a_drv = '0;
  logic [G-1:0] b_drv = '0;

  int total = 0;
  int bad   = 0;

  ic7402_quad_nor_if #(.GATES(G)) bus1 ();
  ic7402_quad_nor_if #(.GATES(G)) bus2 ();

  assign bus1.a = a_drv;
  assign bus1.b = b_drv;
  assign bus2.a = a_drv;
  assign bus2.b = b_drv;

  ic7402_quad_nor #(.GATES(G), .PIPE_STAGES(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  ic7402_quad_nor #(.GATES(G), .PIPE_STAGES(2)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Truth table per lane: only 00 gives 1.
  function automatic logic [G-1:0] nor_ref(input logic [G-1:0] a, input logic [G-1:0] b);
    logic [G-1:0] r;
    for (int i = 0; i < G; i++) begin
      case ({a[i], b[i]})
        2'b00:   r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  logic [G-1:0] hist_y[$];
  bit           hist_rst[$];
  int           n_edges = 0;

  always @(posedge clk) begin
    hist_y.push_back(nor_ref(a_drv, b_drv));
    hist_rst.push_back(!rst_n);
    n_edges++;
  end

  // y_q after edge n for depth p: value sampled p-1 edges earlier, unless a
  // reset edge lies inside that window, in which case all-ones.
  function automatic logic [G-1:0] model_yq(input int n, input int p);
    if (n < 0) return '1;
    for (int k = n - p + 1; k <= n; k++) begin
      if (k < 0) return '1;
      if (hist_rst[k]) return '1;
    end
    return hist_y[n - p + 1];
  endfunction

  function automatic logic [G-1:0] model_chg(input int n, input int p);
    if (n < 0 || hist_rst[n]) return '0;
    return model_yq(n, p) ^ model_yq(n - 1, p);
  endfunction

  task automatic chk(input string name, input logic [G-1:0] act, input logic [G-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (n_edges > 0) begin
      chk("u1_y",     bus1.y,     nor_ref(a_drv, b_drv));
      chk("u2_y",     bus2.y,     nor_ref(a_drv, b_drv));
      chk("u1_y_q",   bus1.y_q,   model_yq(n_edges - 1, 1));
      chk("u1_y_chg", bus1.y_chg, model_chg(n_edges - 1, 1));
      chk("u2_y_q",   bus2.y_q,   model_yq(n_edges - 1, 2));
      chk("u2_y_chg", bus2.y_chg, model_chg(n_edges - 1, 2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [G-1:0] a, input logic [G-1:0] b, input logic r);
    @(negedge clk);
    #1;
    a_drv = a;
    b_drv = b;
    rst_n = r;
    $display("step t=%0t a=%b b=%b rst_n=%b", $time, a, b, r);
  endtask

  initial begin
    logic [1:0] pat_a;
    logic [1:0] pat_b;
    logic [G-1:0] ea;
    logic [G-1:0] eb;
    logic [G-1:0] ey;

    // Reset with zero inputs.
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    chk("rst_u1_y_q",   bus1.y_q,   4'b1111);
    chk("rst_u1_y_chg", bus1.y_chg, 4'b0000);
    chk("rst_u2_y_q",   bus2.y_q,   4'b1111);
    chk("rst_u2_y_chg", bus2.y_chg, 4'b0000);

    // Truth table walk through every gate: 00, 10, 11, 01.
    for (int g = 0; g < G; g++) begin
      for (int s = 0; s < 4; s++) begin
        pat_a = (s == 1 || s == 2) ? 2'b01 : 2'b00;
        pat_b = (s == 2 || s == 3) ? 2'b01 : 2'b00;
        ea = '0; eb = '0;
        ea[g] = pat_a[0];
        eb[g] = pat_b[0];
        step(ea, eb, 1'b1);
        #1;
        ey = 4'b1111;
        ey[g] = (s == 0) ? 1'b1 : 1'b0;
        chk($sformatf("tt_g%0d_s%0d", g, s), bus1.y, ey);
      end
    end

    // Latency with PIPE_STAGES=2.
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    chk("lat_pre_y_q", bus2.y_q, 4'b1111);
    step(4'b0001, '0, 1'b1);
    #1;
    chk("lat_y_now", bus2.y, 4'b1110);
    @(negedge clk);
    chk("lat_e1_y_q",   bus2.y_q,   4'b1111);
    chk("lat_e1_y_chg", bus2.y_chg, 4'b0000);
    @(negedge clk);
    chk("lat_e2_y_q",   bus2.y_q,   4'b1110);
    chk("lat_e2_y_chg", bus2.y_chg, 4'b0001);
    @(negedge clk);
    chk("lat_e3_y_chg", bus2.y_chg, 4'b0000);

    // Mid-operation reset with y_q at 0000.
    step(4'b1111, '0, 1'b1);
    step(4'b1111, '0, 1'b1);
    step(4'b1111, '0, 1'b1);
    chk("mrst_pre_u1_y_q", bus1.y_q, 4'b0000);
    chk("mrst_pre_u2_y_q", bus2.y_q, 4'b0000);
    step(4'b1111, '0, 1'b0);
    @(negedge clk);
    chk("mrst_u1_y_q",   bus1.y_q,   4'b1111);
    chk("mrst_u1_y_chg", bus1.y_chg, 4'b0000);
    chk("mrst_u2_y_q",   bus2.y_q,   4'b1111);
    chk("mrst_u2_y_chg", bus2.y_chg, 4'b0000);
    chk("mrst_y",        bus1.y,     4'b0000);

    // Multi-lane change with PIPE_STAGES=1.
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step(4'b0101, '0, 1'b1);
    @(negedge clk);
    chk("ml_y_q",    bus1.y_q,   4'b1010);
    chk("ml_y_chg",  bus1.y_chg, 4'b0101);
    @(negedge clk);
    chk("ml_y_chg2", bus1.y_chg, 4'b0000);

    // Sub-cycle glitch on b[2].
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    @(negedge clk);
    #1;
    b_drv = 4'b0100;
    #2;
    chk("gl_y", bus1.y, 4'b1011);
    #1;
    b_drv = 4'b0000;
    @(negedge clk);
    chk("gl_y_q",   bus1.y_q,   4'b1111);
    chk("gl_y_chg", bus1.y_chg, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(G'($urandom), G'($urandom), ($urandom_range(0, 19) != 0));
    end
    step('0, '0, 1'b1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ic7402_quad_nor

// File: doc/ic7402_quad_nor.md
Name: ic7402_quad_nor

Overview:
- Synthesizable model of the 7402 quad 2-input NOR package, used in the 74xxx simulation library.
- Provides the classic combinational NOR outputs, y[i] = ~(a[i] | b[i]).
- Adds a clocked, resettable registered copy of the outputs with configurable pipeline depth, plus a per-gate output-change strobe, so synchronous logic can sample the gates cleanly.

Parameters:
- GATES, 4, number of independent 2-input NOR gates (7402 = 4).
- PIPE_STAGES, 1, register stages on y_q. Legal range 1..4; values outside are a compile-time error.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- a  input  GATES  first input of each gate; a[i] feeds gate i.
- b  input  GATES  second input of each gate; b[i] feeds gate i.
- y  output  GATES  combinational NOR outputs, y[i] = ~(a[i] | b[i]).
- y_q  output  GATES  y delayed by PIPE_STAGES clock cycles.
- y_chg  output  GATES  one-cycle strobe; bit i is high when y_q[i] changed on the last clock edge.

Behaviour:
Combinational path (y):
- Pure combinational; no dependence on clk or rst_n. Valid even while rst_n = 0.
- Truth table per gate (a,b -> y): 00->1, 01->0, 10->0, 11->0.
- Gates are fully independent; no cross-coupling between bit lanes.

Registered path (y_q):
- Stage 1 captures y on each rising clk edge. Stage k captures stage k-1.
- y_q is the last stage. Latency from an a/b change to y_q is exactly PIPE_STAGES rising edges.

Change strobe (y_chg):
- Registered. On each edge, y_chg[i] <= (next y_q[i] != current y_q[i]).
- Therefore y_chg is high in the same cycle y_q shows the new value.
- It lasts exactly one cycle per transition.

Reset:
- When rst_n = 0 at a rising edge, every pipeline stage loads all-ones.
- All-ones is the NOR value of all-zero inputs, so y_q resets to {GATES{1'b1}}.
- y_chg resets to 0.
- Reset overrides normal capture in the same edge.
- No X propagates from reset.

Reset release and mid-operation reset:
- First edge with rst_n = 1 resumes normal capture.
- If inputs are zero at release, y_chg stays 0. If an input is already 1, y_chg pulses once the new value reaches y_q.
- Reset asserted mid-operation discards all in-flight pipeline data on that edge.
- y_q returns to all-ones. y_chg is forced to 0 on that edge, even if y_q was not all-ones before.

Other rules:
- Simultaneous changes on several gates: each lane strobes independently in the same cycle.
- Input change and back within one clock period (glitch): only the value sampled at the edge matters. No strobe if the sampled y is unchanged.
- X/Z on inputs: no special handling required. Behaviour follows standard Verilog operator semantics.

Test Plan:
1. Truth table, gate 0: a=b=0000, step a[0]=1, then b[0]=1, then a[0]=0 at 10-unit intervals.
   - Required y[0] sequence: 1, 0, 0, 0.
   - Required y[3:1] = 111 throughout.
2. Walk the same a/b sequence through gates 1, 2 and 3 in turn.
   - Only the gate under test leaves 1.
   - For every gate: 00->1, 10->0, 11->0, 01->0.
3. Latency, PIPE_STAGES=2, rst_n=1, a=b=0000, y_q=1111: set a=0001.
   - y drops to 1110 immediately.
   - y_q becomes 1110 on the 2nd rising edge, and y_chg=0001 for that single cycle.
4. Reset mid-operation: a=1111 with y_q=0000, then hold rst_n=0 for one edge.
   - On that edge: y_q=1111, y_chg=0000.
   - Combinational y stays 0000 throughout.
5. Multi-lane change: toggle a from 0000 to 0101 with PIPE_STAGES=1.
   - Next edge: y_q=1010 and y_chg=0101.
   - Following edge: y_chg=0000.
6. Sub-cycle glitch: pulse b[2] high for less than one clock period between two edges.
   - y[2] pulses low.
   - y_q[2] stays 1 and y_chg[2] stays 0.
